// File: rtl/demux_frame_sequencer.sv
// Bit-serial frame receiver driving the 1:8 DEMUX: start bit, 3-bit address (MSB first),
// PAYLOAD_BITS payload bits steered out on Data/Enable, then a stop bit and an idle gap.
module demux_frame_sequencer #(
  parameter int PAYLOAD_BITS = 8,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       Clock_In,
  input  logic       Reset_n_In,
  input  logic       Serial_In,
  input  logic       Serial_Valid_In,
  output logic       Busy_Out,
  output logic       Enable_Out,
  output logic       Data_Out,
  output logic [2:0] Select_Out,
  output logic       Frame_Done_Out,
  output logic       Error_Out,
  output logic [7:0] Frame_Count_Out,
  output logic [2:0] state_dbg
);

  localparam int PW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_BITS - 1);
  localparam logic [PW-1:0] PAY_ONE  = PW'(1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    STOP = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t        state;
  logic [1:0]    addr_sr;
  logic [1:0]    addr_cnt;
  logic [PW-1:0] pay_cnt;
  logic [7:0]    gap_cnt;

  assign state_dbg = state;

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state           <= IDLE;
      addr_sr         <= '0;
      addr_cnt        <= '0;
      pay_cnt         <= '0;
      gap_cnt         <= '0;
      Busy_Out        <= 1'b0;
      Enable_Out      <= 1'b0;
      Data_Out        <= 1'b0;
      Select_Out      <= '0;
      Frame_Done_Out  <= 1'b0;
      Error_Out       <= 1'b0;
      Frame_Count_Out <= '0;
    end else begin
      Frame_Done_Out <= 1'b0;
      Error_Out      <= 1'b0;
      case (state)
        IDLE: begin
          // Only a strobed 1 starts a frame; strobed zeros are line idle.
          if (Serial_Valid_In && Serial_In) begin
            state    <= ADDR;
            Busy_Out <= 1'b1;
            addr_cnt <= '0;
          end
        end
        ADDR: begin
          if (Serial_Valid_In) begin
            addr_sr  <= {addr_sr[0], Serial_In};
            addr_cnt <= addr_cnt + 2'd1;
            if (addr_cnt == 2'd2) begin
              Select_Out <= {addr_sr, Serial_In};
              pay_cnt    <= '0;
              state      <= DATA;
            end
          end
        end
        DATA: begin
          if (Serial_Valid_In) begin
            Data_Out   <= Serial_In;
            Enable_Out <= 1'b1;
            pay_cnt    <= pay_cnt + PAY_ONE;
            if (pay_cnt == PAY_LAST) state <= STOP;
          end
        end
        STOP: begin
          if (Serial_Valid_In) begin
            Enable_Out <= 1'b0;
            Data_Out   <= 1'b0;
            gap_cnt    <= '0;
            if (Serial_In) begin
              Frame_Done_Out  <= 1'b1;
              Frame_Count_Out <= Frame_Count_Out + 8'd1;
            end else begin
              Error_Out <= 1'b1;
            end
            if (GAP_CYCLES == 0) begin
              state    <= IDLE;
              Busy_Out <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          // Strobes here are dropped; the gap is timed purely in clocks.
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == GAP_LAST) begin
            state    <= IDLE;
            Busy_Out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          Busy_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Randomized frame stimulus with a frame-level reference model; a negedge monitor
// reassembles each delivered frame from the DEMUX-side outputs and checks it against exp_q.
module tb_demux_frame_sequencer;

  localparam int PB = 8;
  localparam int GC = 3;
  localparam int W  = 29;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sin = 1'b0;
  logic       sv = 1'b0;
  logic       busy, en, dout, done, err;
  logic [2:0] sel, st_dbg;
  logic [7:0] cnt;

  demux_frame_sequencer #(.PAYLOAD_BITS(PB), .GAP_CYCLES(GC)) dut (
    .Clock_In        (clk),
    .Reset_n_In      (rst_n),
    .Serial_In       (sin),
    .Serial_Valid_In (sv),
    .Busy_Out        (busy),
    .Enable_Out      (en),
    .Data_Out        (dout),
    .Select_Out      (sel),
    .Frame_Done_Out  (done),
    .Error_Out       (err),
    .Frame_Count_Out (cnt),
    .state_dbg       (st_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] model_count = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic b);
    sv  = v;
    sin = v ? b : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    sv  = 1'b0;
    sin = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_gaps(input int mode);
    int n;
    n = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_outputs_async", {busy, en, dout, sel, done, err, cnt}, 32'd0);
    model_count = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [2:0] addr, input logic [7:0] pay, input logic stop,
                            input int mode, input int abort_after);
    logic [W-1:0] e;
    drive(1'b1, 1'b1);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 3; i++) begin
      idle_gaps(mode);
      drive(1'b1, addr[2-i]);
    end
    check("select_after_addr", sel, addr);
    for (int i = 0; i < PB; i++) begin
      idle_gaps(mode);
      if (abort_after != 0 && i == abort_after) begin
        apply_reset();
        return;
      end
      drive(1'b1, pay[PB-1-i]);
    end
    if (stop) model_count = model_count + 8'd1;
    // {done, err, count, select, payload, nbits, select_changed, enable, data}
    e = {stop, ~stop, model_count, addr, pay, 5'(PB), 1'b0, 1'b0, 1'b0};
    exp_q.push_back(e);
    idle_gaps(mode);
    drive(1'b1, stop);
    // Strobes during the gap, including a start bit on its first clock, must be dropped.
    for (int i = 0; i < GC; i++) begin
      drive(1'b1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      check("busy_in_gap", busy, (i != GC - 1));
    end
    repeat ($urandom_range(0, 3)) drive(1'b1, 1'b0);
    check("idle_after_zeros", busy, 0);
  endtask

  // ---------------- monitor ----------------
  logic         strobe_seen = 1'b0;
  logic [7:0]   cur_pay = '0;
  logic [4:0]   cur_n = '0;
  logic         selchg = 1'b0;
  logic         prev_en = 1'b0;
  logic [2:0]   sel_first = '0;
  logic [W-1:0] obs;

  always @(posedge clk) strobe_seen = sv;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_pay = '0;
      cur_n   = '0;
      selchg  = 1'b0;
      prev_en = 1'b0;
    end else begin
      if (en && !prev_en) sel_first = sel;
      if (en && prev_en && sel != sel_first) selchg = 1'b1;
      if (en && !strobe_seen && cur_n != 0) check("data_hold", dout, cur_pay[0]);
      if (en && strobe_seen) begin
        cur_pay = {cur_pay[6:0], dout};
        cur_n   = cur_n + 5'd1;
      end
      prev_en = en;
      if (done || err) begin
        check("done_err_exclusive", done & err, 0);
        obs = {done, err, cnt, sel, cur_pay, cur_n, selchg, en, dout};
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame_end: got %0h expected none at %0t", obs, $time);
        end else begin
          check("frame", obs, exp_q.pop_front());
        end
        cur_pay = '0;
        cur_n   = '0;
        selchg  = 1'b0;
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    apply_reset();
    check("reset_state_idle", busy, 0);
    send_frame(3'b101, 8'b10110010, 1'b1, 0, 0);
    send_frame(3'b101, 8'b10110010, 1'b0, 0, 0);
    send_frame(3'b101, 8'b10110010, 1'b1, 1, 0);
    send_frame(3'b110, 8'($urandom), 1'b1, 2, 4);
    check("count_after_abort", cnt, 0);
    send_frame(3'b010, 8'($urandom), 1'b1, 0, 0);
    repeat (30) send_frame(3'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                           int'($urandom_range(0, 2)), 0);
    apply_reset();
    repeat (256) send_frame(3'($urandom), 8'($urandom), 1'b1, 0, 0);
    check("count_wrapped", cnt, 0);
    repeat (20) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
